// File: rtl/irq_ctrl_vec.sv
// irq_ctrl_vec: parametrised vectored interrupt controller, fixed priority
// (lowest source index wins), with a req/ack/eoi handshake to the CPU and an
// MMIO register bank (STATUS, ENABLE, MODE, ACK, INSERV, VECTOR).
//
// Optional feature macro: IRQ_NEST_EN (nested preemption of lower-priority
// service by higher-priority pending sources). Undefined by default.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   src_in[NUM_SRC]       raw interrupt source lines
//   reg_wr/addr/wdata     one-cycle register write strobe, index, data
//   reg_rdata             read data, combinational from reg_addr
//   irq_req, irq_vec      request and winning vector to the CPU
//   irq_ack, irq_eoi      CPU acknowledge and end-of-interrupt pulses
module irq_ctrl_vec #(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned VEC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic               reg_wr,
  input  logic [2:0]         reg_addr,
  input  logic [15:0]        reg_wdata,
  output logic [15:0]        reg_rdata,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vec,
  input  logic               irq_ack,
  input  logic               irq_eoi
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_e;

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_d [SYNC_STAGES];
  logic [NUM_SRC-1:0] sprev_q, sprev_d;
  logic [NUM_SRC-1:0] status_q, status_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] inserv_q, inserv_d;
  state_e             state_q, state_d;
  logic               irq_req_q, irq_req_d;
  logic [VEC_W-1:0]   irq_vec_q, irq_vec_d;

  logic [NUM_SRC-1:0] s, pend, pend_d, set_ev, w1c, take, eoi_clr;
  logic               unused_wdata;

  assign unused_wdata = ^reg_wdata;

  // Index of the lowest set bit, 0 when none.
  function automatic logic [VEC_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = VEC_W'(i);
    end
  endfunction

  // Isolate the lowest set bit as a one-hot mask.
  function automatic logic [NUM_SRC-1:0] lowest_bit(input logic [NUM_SRC-1:0] v);
    return v & (~v + NUM_SRC'(1));
  endfunction

`ifdef IRQ_NEST_EN
  // Pending source strictly outranks everything in service; one-hot masks
  // compare numerically in index order.
  function automatic logic preempts(input logic [NUM_SRC-1:0] p,
                                    input logic [NUM_SRC-1:0] sv);
    return (p != '0) && ((sv == '0) || (lowest_bit(p) < lowest_bit(sv)));
  endfunction
`endif

  // Next-state: synchroniser, register bank, handshake FSM.
  always_comb begin
    sync_d[0] = src_in;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    s       = sync_q[SYNC_STAGES-1];
    sprev_d = s;
    pend    = status_q & enable_q;
    set_ev  = (s & ~sprev_q & mode_q) | (s & ~mode_q);

    enable_d = (reg_wr && reg_addr == 3'd1) ? reg_wdata[NUM_SRC-1:0] : enable_q;
    mode_d   = (reg_wr && reg_addr == 3'd2) ? reg_wdata[NUM_SRC-1:0] : mode_q;
    w1c      = (reg_wr && reg_addr == 3'd3) ? reg_wdata[NUM_SRC-1:0] : '0;

    state_d = state_q;
    take    = '0;
    eoi_clr = '0;
    case (state_q)
      ST_IDLE: if (pend != '0) state_d = ST_REQ;
      ST_REQ: begin
        // A vanished request wins over a same-cycle ack.
        if (pend == '0) state_d = ST_IDLE;
        else if (irq_ack) begin
          take    = lowest_bit(pend);
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
`ifdef IRQ_NEST_EN
        if (irq_ack && preempts(pend, inserv_q)) take = lowest_bit(pend);
        if (irq_eoi) eoi_clr = lowest_bit(inserv_q);
`else
        if (irq_eoi) eoi_clr = inserv_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    inserv_d = (inserv_q & ~eoi_clr) | take;
    if (state_q == ST_SERVICE && inserv_d == '0) state_d = ST_IDLE;

    // Set beats clear so no event is lost.
    status_d = (status_q & ~(w1c | take)) | set_ev;

    // Outputs registered from next-state values so they track pend with no lag.
    pend_d    = status_d & enable_d;
    irq_vec_d = lowest_idx(pend_d);
    irq_req_d = (state_d == ST_REQ);
`ifdef IRQ_NEST_EN
    if (state_d == ST_SERVICE && preempts(pend_d, inserv_d)) irq_req_d = 1'b1;
`endif
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      sprev_q   <= '0;
      status_q  <= '0;
      enable_q  <= '0;
      mode_q    <= '1;
      inserv_q  <= '0;
      state_q   <= ST_IDLE;
      irq_req_q <= 1'b0;
      irq_vec_q <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      sprev_q   <= sprev_d;
      status_q  <= status_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      inserv_q  <= inserv_d;
      state_q   <= state_d;
      irq_req_q <= irq_req_d;
      irq_vec_q <= irq_vec_d;
    end
  end

  assign irq_req = irq_req_q;
  assign irq_vec = irq_vec_q;

  // Register read mux; unused bits and addresses read 0.
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      3'd0:    reg_rdata = 16'(status_q);
      3'd1:    reg_rdata = 16'(enable_q);
      3'd2:    reg_rdata = 16'(mode_q);
      3'd4:    reg_rdata = 16'(inserv_q);
      3'd5:    reg_rdata = {(pend != '0), 15'(irq_vec_q)};
      default: reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl_vec.sv
// Testbench for irq_ctrl_vec: directed scenarios followed by randomized
// transactions served by a CPU-like monitor against a queue of expected vectors.
module tb_irq_ctrl_vec;

  localparam int unsigned NS = 8;
  localparam int unsigned S  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] src_in;
  logic          reg_wr;
  logic [2:0]    reg_addr;
  logic [15:0]   reg_wdata;
  logic [15:0]   reg_rdata;
  logic          irq_req;
  logic [2:0]    irq_vec;
  logic          irq_ack;
  logic          irq_eoi;
  logic          d_ack, d_eoi, m_ack, m_eoi;

  assign irq_ack = d_ack | m_ack;
  assign irq_eoi = d_eoi | m_eoi;

  irq_ctrl_vec #(.NUM_SRC(NS), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .src_in(src_in),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack), .irq_eoi(irq_eoi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  logic mon_en   = 1'b0;
  logic mon_busy = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick(1);
    reg_wr = 1'b0;
  endtask

  task automatic chk_reg(input string nm, input logic [2:0] a, input logic [15:0] exp);
    reg_addr = a;
    #1;
    check(nm, reg_rdata, exp);
  endtask

  task automatic pulse(input logic [NS-1:0] m);
    src_in = src_in | m;
    tick(1);
    src_in = src_in & ~m;
  endtask

  task automatic wait_req(input string nm, input int max);
    int i = 0;
    while (!irq_req && i < max) begin tick(1); i++; end
    check(nm, irq_req, 1);
  endtask

  task automatic do_ack();
    d_ack = 1'b1; tick(1); d_ack = 1'b0;
  endtask

  task automatic do_eoi();
    d_eoi = 1'b1; tick(1); d_eoi = 1'b0;
  endtask

  task automatic serve(input string nm, input int v);
    wait_req({nm, "_req"}, 30);
    check({nm, "_vec"}, irq_vec, v);
    do_ack();
    check({nm, "_req_after_ack"}, irq_req, 0);
    do_eoi();
  endtask

  // CPU-side monitor: serves each request and compares against the queue.
  initial begin
    m_ack = 1'b0; m_eoi = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && irq_req) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) check("mon_unexpected_req", irq_req, 0);
        else check("mon_vec", irq_vec, exp_q.pop_front());
        m_ack = 1'b1; @(negedge clk); m_ack = 1'b0;
        check("mon_req_after_ack", irq_req, 0);
        m_eoi = 1'b1; @(negedge clk); m_eoi = 1'b0;
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS-1:0] model_status, pulses, en, w;
    reset = 1'b1; src_in = '0; reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0;
    d_ack = 1'b0; d_eoi = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state.
    check("rst_req", irq_req, 0);
    check("rst_vec", irq_vec, 0);
    chk_reg("rst_status", 3'd0, 16'h0000);
    chk_reg("rst_enable", 3'd1, 16'h0000);
    chk_reg("rst_mode", 3'd2, 16'h00FF);
    chk_reg("rst_inserv", 3'd4, 16'h0000);
    chk_reg("rst_vector", 3'd5, 16'h0000);
    chk_reg("rst_addr6", 3'd6, 16'h0000);

    // Ack outside REQ is ignored.
    do_ack();
    chk_reg("idle_ack_inserv", 3'd4, 16'h0000);

    // Single source latency and handshake.
    reg_write(3'd1, 16'h0004);
    chk_reg("en_readback", 3'd1, 16'h0004);
    src_in = 8'h04; tick(1); src_in = '0;
    tick(S - 1);
    chk_reg("lat_status_early", 3'd0, 16'h0000);
    tick(1);
    chk_reg("lat_status_set", 3'd0, 16'h0004);
    check("lat_req_not_yet", irq_req, 0);
    tick(1);
    check("lat_req", irq_req, 1);
    check("lat_vec", irq_vec, 2);
    chk_reg("lat_vector_reg", 3'd5, 16'h8002);
    do_eoi();
    check("req_eoi_ignored", irq_req, 1);
    do_ack();
    check("ack_req", irq_req, 0);
    chk_reg("ack_status", 3'd0, 16'h0000);
    chk_reg("ack_inserv", 3'd4, 16'h0004);
    do_eoi();
    chk_reg("eoi_inserv", 3'd4, 16'h0000);
    tick(2);
    check("eoi_req_quiet", irq_req, 0);

    // Two simultaneous edges: priority order 1 then 5.
    reg_write(3'd1, 16'h00FF);
    pulse(8'h22);
    serve("prio_first", 1);
    serve("prio_second", 5);
    tick(3);
    chk_reg("prio_status", 3'd0, 16'h0000);
    check("prio_req_quiet", irq_req, 0);

    // Level source re-requests while held.
    reg_write(3'd2, 16'h00F7);
    src_in = 8'h08;
    wait_req("lvl_req", 30);
    check("lvl_vec", irq_vec, 3);
    do_ack();
    chk_reg("lvl_status_reset", 3'd0, 16'h0008);
    chk_reg("lvl_inserv", 3'd4, 16'h0008);
    do_eoi();
    wait_req("lvl_rereq", 30);
    check("lvl_rereq_vec", irq_vec, 3);
    src_in = '0;
    tick(S + 2);
    do_ack();
    chk_reg("lvl_drop_status", 3'd0, 16'h0000);
    do_eoi();
    tick(5);
    check("lvl_drop_req", irq_req, 0);
    reg_write(3'd2, 16'h00FF);

    // Disable while requesting.
    reg_write(3'd1, 16'h0010);
    pulse(8'h10);
    wait_req("dis_req", 30);
    check("dis_vec", irq_vec, 4);
    reg_write(3'd1, 16'h0000);
    tick(1);
    check("dis_req_fall", irq_req, 0);
    chk_reg("dis_status", 3'd0, 16'h0010);
    chk_reg("dis_vector", 3'd5, 16'h0000);
    tick(2);
    check("dis_idle", irq_req, 0);
    reg_write(3'd3, 16'h0010);
    chk_reg("w1c_status", 3'd0, 16'h0000);

    // W1C colliding with a new edge on src 0 keeps the bit set.
    src_in = 8'h01; tick(1); src_in = '0;
    tick(S - 1);
    reg_write(3'd3, 16'h0001);
    chk_reg("collide_status", 3'd0, 16'h0001);
    reg_write(3'd3, 16'h0001);
    chk_reg("collide_cleared", 3'd0, 16'h0000);

    // Higher priority arriving while servicing vec 6.
    reg_write(3'd1, 16'h00FF);
    pulse(8'h40);
    wait_req("nest_req6", 30);
    check("nest_vec6", irq_vec, 6);
    do_ack();
    chk_reg("nest_inserv6", 3'd4, 16'h0040);
    src_in = 8'h04; tick(1); src_in = '0;
    tick(S + 1);
    check("nest_vec2", irq_vec, 2);
`ifdef IRQ_NEST_EN
    check("nest_req2", irq_req, 1);
    do_ack();
    chk_reg("nest_inserv44", 3'd4, 16'h0044);
    check("nest_req_after_ack", irq_req, 0);
    do_eoi();
    chk_reg("nest_inserv40", 3'd4, 16'h0040);
    do_eoi();
    chk_reg("nest_inserv0", 3'd4, 16'h0000);
    tick(2);
    check("nest_idle_req", irq_req, 0);
`else
    check("nonest_req2", irq_req, 0);
    tick(3);
    check("nonest_req_hold", irq_req, 0);
    do_eoi();
    chk_reg("nonest_inserv0", 3'd4, 16'h0000);
    serve("nonest_then2", 2);
    chk_reg("nonest_inserv_end", 3'd4, 16'h0000);
`endif
    chk_reg("nest_status_end", 3'd0, 16'h0000);

    // Reset in the middle of service.
    reg_write(3'd1, 16'h0001);
    pulse(8'h01);
    wait_req("mid_req", 30);
    do_ack();
    chk_reg("mid_inserv", 3'd4, 16'h0001);
    reset = 1'b1;
    #1;
    check("mid_rst_req", irq_req, 0);
    chk_reg("mid_rst_inserv", 3'd4, 16'h0000);
    chk_reg("mid_rst_enable", 3'd1, 16'h0000);
    chk_reg("mid_rst_mode", 3'd2, 16'h00FF);
    tick(1);
    reset = 1'b0;
    tick(2);

    // Randomized: sticky STATUS model, ascending-index service order.
    model_status = '0;
    mon_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      reg_write(3'd1, 16'h0000);
      pulses = NS'($urandom_range(0, 255));
      if (pulses != '0) pulse(pulses);
      model_status = model_status | pulses;
      tick(S + 2);
      chk_reg("rnd_status", 3'd0, 16'(model_status));
      if ($urandom_range(0, 3) == 0) begin
        w = NS'($urandom_range(0, 255));
        reg_write(3'd3, 16'(w));
        model_status = model_status & ~w;
      end
      en = ($urandom_range(0, 3) == 0) ? 8'hFF : NS'($urandom_range(0, 255));
      for (int i = 0; i < NS; i++) if (model_status[i] && en[i]) exp_q.push_back(i);
      reg_write(3'd1, 16'(en));
      for (int i = 0; i < 400 && (exp_q.size() != 0 || mon_busy); i++) tick(1);
      check("rnd_drain", exp_q.size(), 0);
      exp_q.delete();
      tick(2);
      model_status = model_status & ~en;
      check("rnd_req_idle", irq_req, 0);
      chk_reg("rnd_status_after", 3'd0, 16'(model_status));
      chk_reg("rnd_inserv", 3'd4, 16'h0000);
    end
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
